// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared constants for the HUB75 scan controller.
// Holds the fixed panel geometry, the colour bit positions inside each frame-buffer
// byte and the FSM state encoding used by hub75_scan_ctrl.
package hub75_scan_ctrl_pkg;

    // Panel geometry: 16 row pairs, 64 columns, 8 columns per 64-bit word.
    localparam int unsigned ROWS          = 16;
    localparam int unsigned COLS_PER_WORD = 8;
    localparam int unsigned WORDS_PER_ROW = 8;
    localparam int unsigned COL_BITS      = 8;

    // Colour bit positions inside one column byte; bits 7:6 are unused.
    localparam int unsigned IDX_R1 = 5;
    localparam int unsigned IDX_G1 = 4;
    localparam int unsigned IDX_B1 = 3;
    localparam int unsigned IDX_R2 = 2;
    localparam int unsigned IDX_G2 = 1;
    localparam int unsigned IDX_B2 = 0;

    // FSM state encoding.
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StWait    = 3'd2;
    localparam logic [2:0] StShift   = 3'd3;
    localparam logic [2:0] StBlank   = 3'd4;
    localparam logic [2:0] StLatch   = 3'd5;
    localparam logic [2:0] StDisplay = 3'd6;

endpackage

// File: rtl/hub75_bank_swap.sv
// Double-buffer bank arbiter for the HUB75 scan controller.
// A swap request from the writer is held pending until the next frame end, where the
// display bank toggles and a one-cycle acknowledge is issued.  Requests arriving while
// one is already pending collapse into a single swap.
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   swap_req_i   single-cycle "back bank complete" pulse
//   frame_end_i  high in the cycle the scan wraps from row 15 to row 0
//   disp_bank_o  bank currently being displayed
//   swap_ack_o   single-cycle pulse in the first cycle the new bank is in effect
module hub75_bank_swap #(
    parameter logic ON_RESET_BANK = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic swap_req_i,
    input  logic frame_end_i,
    output logic disp_bank_o,
    output logic swap_ack_o
);

    logic pend_q, pend_d;
    logic bank_q, bank_d;
    logic ack_q, ack_d;

    always_comb begin
        pend_d = pend_q | swap_req_i;
        bank_d = bank_q;
        ack_d  = 1'b0;
        // A request landing in the frame-end cycle itself is honoured immediately.
        if (frame_end_i && (pend_q || swap_req_i)) begin
            bank_d = ~bank_q;
            ack_d  = 1'b1;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            bank_q <= ON_RESET_BANK;
            ack_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            bank_q <= bank_d;
            ack_q  <= ack_d;
        end
    end

    assign disp_bank_o = bank_q;
    assign swap_ack_o  = ack_q;

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller (16 row pairs x 64 columns, double-buffered).
// Fetches 64-bit words from a frame-buffer BRAM, shifts them out two cycles per column,
// then blanks, latches and lights each row for CFG_on_cycles cycles.
//   HUB_clk / HUB_rst           clock, synchronous active-high reset
//   RD_addr / RD_en / RD_data   frame-buffer read port {bank, row, word}, 1-cycle latency
//   FB_swap_req / FB_swap_ack   writer bank-swap handshake; FB_wr_bank = back bank
//   CFG_on_cycles               row on-time in cycles (0 = never light)
//   HUB_*                       panel colour, shift clock, latch, output enable, row address
module hub75_scan_ctrl
    import hub75_scan_ctrl_pkg::*;
#(
    parameter logic ON_RESET_BANK = 1'b0
) (
    input  logic        HUB_clk,
    input  logic        HUB_rst,
    output logic [7:0]  RD_addr,
    output logic        RD_en,
    input  logic [63:0] RD_data,
    input  logic        FB_swap_req,
    output logic        FB_swap_ack,
    output logic        FB_wr_bank,
    input  logic [7:0]  CFG_on_cycles,
    output logic        HUB_r1,
    output logic        HUB_g1,
    output logic        HUB_b1,
    output logic        HUB_r2,
    output logic        HUB_g2,
    output logic        HUB_b2,
    output logic        HUB_sclk,
    output logic        HUB_lat,
    output logic        HUB_oe_n,
    output logic [3:0]  HUB_row
);

    localparam logic [3:0] LastRow  = 4'(ROWS - 1);
    localparam logic [2:0] LastWord = 3'(WORDS_PER_ROW - 1);
    localparam logic [2:0] LastCol  = 3'(COLS_PER_WORD - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [2:0]  word_q, word_d;
    logic [2:0]  col_q, col_d;
    logic        phase_q, phase_d;
    logic [63:0] shift_q, shift_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  hub_row_q, hub_row_d;
    logic        row_adv;
    logic        frame_end;
    logic        disp_bank;
    logic        shifting;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        word_d    = word_q;
        col_d     = col_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        hub_row_d = hub_row_q;
        row_adv   = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
                row_d   = '0;
                word_d  = '0;
                col_d   = '0;
                phase_d = 1'b0;
            end
            StFetch: state_d = StWait;
            StWait: begin
                shift_d = RD_data;
                col_d   = '0;
                phase_d = 1'b0;
                state_d = StShift;
            end
            StShift: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    shift_d = shift_q >> COL_BITS;
                    col_d   = col_q + 3'd1;
                    if (col_q == LastCol) begin
                        if (word_q == LastWord) begin
                            state_d   = StBlank;
                            // Panel row address follows the row whose data is now in the
                            // shift chain, so it changes while outputs are blanked.
                            hub_row_d = row_q;
                        end else begin
                            word_d  = word_q + 3'd1;
                            state_d = StFetch;
                        end
                    end
                end
            end
            StBlank: state_d = StLatch;
            StLatch: begin
                if (CFG_on_cycles == 8'd0) begin
                    row_adv = 1'b1;
                end else begin
                    cnt_d   = CFG_on_cycles;
                    state_d = StDisplay;
                end
            end
            StDisplay: begin
                if (cnt_q <= 8'd1) begin
                    row_adv = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (row_adv) begin
            frame_end = (row_q == LastRow);
            row_d     = frame_end ? 4'd0 : row_q + 4'd1;
            word_d    = '0;
            state_d   = StFetch;
        end
    end

    always_ff @(posedge HUB_clk) begin
        if (HUB_rst) begin
            state_q   <= StIdle;
            row_q     <= '0;
            word_q    <= '0;
            col_q     <= '0;
            phase_q   <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            hub_row_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            word_q    <= word_d;
            col_q     <= col_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            hub_row_q <= hub_row_d;
        end
    end

    hub75_bank_swap #(
        .ON_RESET_BANK (ON_RESET_BANK)
    ) u_bank_swap (
        .clk_i       (HUB_clk),
        .rst_i       (HUB_rst),
        .swap_req_i  (FB_swap_req),
        .frame_end_i (frame_end),
        .disp_bank_o (disp_bank),
        .swap_ack_o  (FB_swap_ack)
    );

    assign shifting   = (state_q == StShift);
    assign RD_en      = (state_q == StFetch);
    // Address is forced to zero outside FETCH so idle outputs don't depend on the bank.
    assign RD_addr    = RD_en ? {disp_bank, row_q, word_q} : 8'd0;
    assign FB_wr_bank = ~disp_bank;

    assign HUB_r1   = shifting & shift_q[IDX_R1];
    assign HUB_g1   = shifting & shift_q[IDX_G1];
    assign HUB_b1   = shifting & shift_q[IDX_B1];
    assign HUB_r2   = shifting & shift_q[IDX_R2];
    assign HUB_g2   = shifting & shift_q[IDX_G2];
    assign HUB_b2   = shifting & shift_q[IDX_B2];
    assign HUB_sclk = shifting & phase_q;
    assign HUB_lat  = (state_q == StLatch);
    assign HUB_oe_n = (state_q != StDisplay);
    assign HUB_row  = hub_row_q;

    // Bits 7:6 of the column byte carry no colour.
    logic unused_shift;
    assign unused_shift = ^shift_q[7:6];

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl: a BRAM model serves random frame data, a
// scoreboard holds expected fetch addresses and per-column colours, and scenario tasks
// check timing, blanking, bank swapping and reset behaviour.
module tb_hub75_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_addr;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        swap_req;
    logic        swap_ack;
    logic        wr_bank;
    logic [7:0]  cfg_on;
    logic        r1, g1, b1, r2, g2, b2;
    logic        sclk, lat, oe_n;
    logic [3:0]  row;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [256];
    logic [7:0]  exp_addr_q [$];
    logic [5:0]  exp_col_q [$];
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    hub75_scan_ctrl #(
        .ON_RESET_BANK (1'b0)
    ) dut (
        .HUB_clk       (clk),
        .HUB_rst       (rst),
        .RD_addr       (rd_addr),
        .RD_en         (rd_en),
        .RD_data       (rd_data),
        .FB_swap_req   (swap_req),
        .FB_swap_ack   (swap_ack),
        .FB_wr_bank    (wr_bank),
        .CFG_on_cycles (cfg_on),
        .HUB_r1        (r1),
        .HUB_g1        (g1),
        .HUB_b1        (b1),
        .HUB_r2        (r2),
        .HUB_g2        (g2),
        .HUB_b2        (b2),
        .HUB_sclk      (sclk),
        .HUB_lat       (lat),
        .HUB_oe_n      (oe_n),
        .HUB_row       (row)
    );

    // Frame-buffer BRAM: registered read, data valid the cycle after RD_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Scoreboard monitor: pops expectations on every fetch and every sclk rise.
    initial begin
        logic [7:0] ea;
        logic [5:0] ec;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rd_en) begin
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL fetch_addr: got unexpected fetch at %h", rd_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        if (rd_addr !== ea) begin
                            errors++;
                            $display("FAIL fetch_addr: got %h expected %h", rd_addr, ea);
                        end
                    end
                end
                if (sclk) begin
                    checks++;
                    if (exp_col_q.size() == 0) begin
                        errors++;
                        $display("FAIL column_data: got unexpected sclk rise");
                    end else begin
                        ec = exp_col_q.pop_front();
                        if ({r1, g1, b1, r2, g2, b2} !== ec) begin
                            errors++;
                            $display("FAIL column_data: got %b expected %b",
                                     {r1, g1, b1, r2, g2, b2}, ec);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_row(input logic bank, input logic [3:0] r);
        logic [7:0]  a;
        logic [63:0] wd;
        for (int w = 0; w < 8; w++) begin
            a = {bank, r, 3'(w)};
            wd = mem[a];
            exp_addr_q.push_back(a);
            for (int c = 0; c < 8; c++) exp_col_q.push_back(wd[8*c +: 6]);
        end
    endtask

    // Hold reset a few cycles with clean scoreboard; caller pushes then releases.
    task automatic start_run(input logic [7:0] cfg);
        mon_en   = 1'b0;
        rst      = 1'b1;
        swap_req = 1'b0;
        cfg_on   = cfg;
        repeat (3) tick();
        exp_addr_q.delete();
        exp_col_q.delete();
    endtask

    task automatic release_rst();
        mon_en = 1'b1;
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        start_run(8'd4);
        checks++;
        if (rd_en !== 1'b0 || rd_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd: got en=%b addr=%h expected 0/00", rd_en, rd_addr);
        end
        checks++;
        if ({r1, g1, b1, r2, g2, b2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_colour: got %b expected 000000", {r1, g1, b1, r2, g2, b2});
        end
        checks++;
        if (sclk !== 1'b0 || lat !== 1'b0 || oe_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got sclk=%b lat=%b oe_n=%b expected 0/0/1", sclk, lat, oe_n);
        end
        checks++;
        if (row !== 4'd0 || swap_ack !== 1'b0 || wr_bank !== 1'b1) begin
            errors++;
            $display("FAIL reset_misc: got row=%0d ack=%b wr_bank=%b expected 0/0/1",
                     row, swap_ack, wr_bank);
        end
    endtask

    task automatic test_first_word();
        start_run(8'd4);
        push_row(1'b0, 4'd0);
        release_rst();
        tick();
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_fetch: got en=%b addr=%h expected 1/00", rd_en, rd_addr);
        end
        tick();
        tick();
        checks++;
        if (sclk !== 1'b0) begin
            errors++;
            $display("FAIL first_phase0: got sclk=%b expected 0", sclk);
        end
        tick();
        checks++;
        if (sclk !== 1'b1 || {r1, g1, b1, r2, g2, b2} !== 6'h3F) begin
            errors++;
            $display("FAIL first_rise: got sclk=%b colour=%b expected 1/111111",
                     sclk, {r1, g1, b1, r2, g2, b2});
        end
        repeat (16) tick();
    endtask

    task automatic test_row_timing();
        int n_fetch = 0, n_sclk = 0, n_lat = 0, n_oe = 0;
        int last_sclk = -1, lat_idx = -1, oe_first = -1;
        start_run(8'd4);
        push_row(1'b0, 4'd0);
        push_row(1'b0, 4'd1);
        push_row(1'b0, 4'd2);
        release_rst();
        for (int i = 0; i <= 296; i++) begin
            tick();
            if (i < 150) begin
                if (rd_en) n_fetch++;
                if (sclk) begin n_sclk++; last_sclk = i; end
                if (lat) begin
                    n_lat++;
                    lat_idx = i;
                    checks++;
                    if (row !== 4'd0) begin
                        errors++;
                        $display("FAIL latch_row: got %0d expected 0", row);
                    end
                end
                if (!oe_n) begin
                    n_oe++;
                    if (oe_first < 0) oe_first = i;
                end
            end
            if (i == 150) begin
                checks++;
                if (rd_en !== 1'b1 || rd_addr !== 8'h08) begin
                    errors++;
                    $display("FAIL next_row_fetch: got en=%b addr=%h expected 1/08", rd_en, rd_addr);
                end
            end
            if (i == 293 || i == 294) begin
                checks++;
                if (row !== ((i == 294) ? 4'd1 : 4'd0)) begin
                    errors++;
                    $display("FAIL blank_row_update: idx %0d got row %0d", i, row);
                end
            end
        end
        checks++;
        if (n_fetch != 8 || n_sclk != 64 || last_sclk != 143) begin
            errors++;
            $display("FAIL row_shift: got fetch=%0d sclk=%0d last=%0d expected 8/64/143",
                     n_fetch, n_sclk, last_sclk);
        end
        checks++;
        if (n_lat != 1 || lat_idx != 145) begin
            errors++;
            $display("FAIL row_latch: got count=%0d idx=%0d expected 1/145", n_lat, lat_idx);
        end
        checks++;
        if (n_oe != 4 || oe_first != 146) begin
            errors++;
            $display("FAIL row_display: got count=%0d first=%0d expected 4/146", n_oe, oe_first);
        end
    endtask

    task automatic test_zero_cfg();
        int n_oe = 0, n_lat = 0;
        start_run(8'd0);
        push_row(1'b0, 4'd0);
        push_row(1'b0, 4'd1);
        push_row(1'b0, 4'd2);
        release_rst();
        for (int i = 0; i <= 292; i++) begin
            tick();
            if (!oe_n) n_oe++;
            if (lat) n_lat++;
            if (i == 145) begin
                checks++;
                if (rd_en !== 1'b0 || lat !== 1'b1) begin
                    errors++;
                    $display("FAIL zero_latch: got en=%b lat=%b expected 0/1", rd_en, lat);
                end
            end
            if (i == 146 || i == 292) begin
                checks++;
                if (rd_en !== 1'b1 || rd_addr !== ((i == 146) ? 8'h08 : 8'h10)) begin
                    errors++;
                    $display("FAIL zero_period: idx %0d got en=%b addr=%h", i, rd_en, rd_addr);
                end
            end
        end
        checks++;
        if (n_oe != 0 || n_lat != 2) begin
            errors++;
            $display("FAIL zero_oe: got oe_low=%0d lat=%0d expected 0/2", n_oe, n_lat);
        end
    endtask

    // Frame = 16 rows x 146 cycles with CFG 0; row 15 LATCH (frame end) at index 2335.
    task automatic test_swap(input bit coincident);
        int n_ack = 0;
        start_run(8'd0);
        for (int r = 0; r < 16; r++) push_row(1'b0, 4'(r));
        push_row(1'b1, 4'd0);
        release_rst();
        for (int i = 0; i <= 2340; i++) begin
            tick();
            if (swap_ack) n_ack++;
            if (i == 2000 || i == 2335) begin
                checks++;
                if (wr_bank !== 1'b1 || swap_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL swap_early: idx %0d got wr_bank=%b ack=%b expected 1/0",
                             i, wr_bank, swap_ack);
                end
            end
            if (i == 2336) begin
                checks++;
                if (swap_ack !== 1'b1 || wr_bank !== 1'b0 || rd_en !== 1'b1 || rd_addr !== 8'h80) begin
                    errors++;
                    $display("FAIL swap_wrap: got ack=%b wr_bank=%b en=%b addr=%h expected 1/0/1/80",
                             swap_ack, wr_bank, rd_en, rd_addr);
                end
            end
            swap_req = coincident ? (i == 2335) : (i == 500 || i == 700);
        end
        checks++;
        if (n_ack != 1) begin
            errors++;
            $display("FAIL swap_count: got %0d acks expected 1", n_ack);
        end
        mon_en = 1'b0;
        rst    = 1'b1;
        tick();
        checks++;
        if (wr_bank !== 1'b1 || swap_ack !== 1'b0) begin
            errors++;
            $display("FAIL swap_reset: got wr_bank=%b ack=%b expected 1/0", wr_bank, swap_ack);
        end
    endtask

    // Row 5 FETCH at 750 (150 cycles/row); index 761 is column 4 phase 1 of word 0.
    task automatic test_reset_mid_shift();
        start_run(8'd4);
        for (int r = 0; r < 6; r++) push_row(1'b0, 4'(r));
        release_rst();
        for (int i = 0; i <= 761; i++) tick();
        checks++;
        if (sclk !== 1'b1 || row !== 4'd4) begin
            errors++;
            $display("FAIL pre_reset: got sclk=%b row=%0d expected 1/4", sclk, row);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (oe_n !== 1'b1 || sclk !== 1'b0 || row !== 4'd0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got oe_n=%b sclk=%b row=%0d en=%b expected 1/0/0/0",
                     oe_n, sclk, row, rd_en);
        end
        exp_addr_q.delete();
        exp_col_q.delete();
        push_row(1'b0, 4'd0);
        rst = 1'b0;
        tick();
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 8'h00) begin
            errors++;
            $display("FAIL restart_fetch: got en=%b addr=%h expected 1/00", rd_en, rd_addr);
        end
        repeat (40) tick();
    endtask

    initial begin
        rst      = 1'b1;
        swap_req = 1'b0;
        cfg_on   = 8'd4;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom(), $urandom()};
        mem[0] = 64'h0000_0000_0000_003F;
        test_reset();
        test_first_word();
        test_row_timing();
        test_zero_cfg();
        test_swap(1'b0);
        test_swap(1'b1);
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
